// File: rtl/pwm_ctrl_pkg.sv
// Shared types, defaults and helpers for the PWM duty controller.
// Imported by btn_debounce and pwm_duty_ctrl.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UP,
    ST_DN,
    ST_BOTH
  } duty_st_e;

  localparam int DEF_DUTY_W        = 4;
  localparam int DEF_DUTY_STEP     = 1;
  localparam int DEF_RESET_DUTY    = 8;
  localparam int DEF_DEB_CYCLES    = 4;
  localparam int DEF_REPEAT_DELAY  = 16;
  localparam int DEF_REPEAT_PERIOD = 4;

  // Largest value a duty register of width w can hold.
  function automatic int duty_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/pwm_duty_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser plus a stability counter.
// Emits the debounced level and a one-cycle pulse on its rising edge.
module btn_debounce
  import pwm_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             rise_q, rise_d;

  // Count samples that disagree with the level; flip once enough agree.
  always_comb begin
    sync_d = {sync_q[0], i_btn};
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    if (cnt_q == CNT_W'(DEB_CYCLES)) begin
      lvl_d  = ~lvl_q;
      rise_d = ~lvl_q;
      cnt_d  = '0;
    end else if (sync_q[1] != lvl_q) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  // Synchroniser, counter and level registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
    end
  end

  assign o_level = lvl_q;
  assign o_rise  = rise_q;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Duty-cycle front end: debounced up/down buttons, arbitration FSM,
// saturating duty register. Auto-repeat: PWM_DUTY_CTRL_AUTO_REPEAT_EN.
module pwm_duty_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W        = DEF_DUTY_W,
  parameter int DUTY_STEP     = DEF_DUTY_STEP,
  parameter int RESET_DUTY    = DEF_RESET_DUTY,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_increase_duty,
  input  logic              i_decrease_duty,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_duty_upd,
  output logic              o_at_max,
  output logic              o_at_min
);

  localparam int DUTY_MAX = duty_max(DUTY_W);

  localparam logic [DUTY_W:0] MAX_X  = (DUTY_W+1)'(DUTY_MAX);
  localparam logic [DUTY_W:0] STEP_X = (DUTY_W+1)'(DUTY_STEP);

  if (DUTY_STEP < 1 || DUTY_STEP > DUTY_MAX) begin : g_bad_step
    $error("DUTY_STEP out of range");
  end
  if (RESET_DUTY < 0 || RESET_DUTY > DUTY_MAX) begin : g_bad_rst
    $error("RESET_DUTY out of range");
  end
  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 2");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_rpt
    $error("REPEAT_PERIOD must be 1..REPEAT_DELAY");
  end

  logic up_lvl, up_rise;
  logic dn_lvl, dn_rise;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_up (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_increase_duty),
    .o_level (up_lvl),
    .o_rise  (up_rise)
  );

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_dn (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_decrease_duty),
    .o_level (dn_lvl),
    .o_rise  (dn_rise)
  );

  duty_st_e          st_q, st_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] prev_q, prev_d;
  logic              upd_q, upd_d;
  logic              do_up, do_dn;
  logic [DUTY_W:0]   sum_x, diff_x;
  logic [DUTY_W-1:0] up_val, dn_val;

`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_fire;
  assign rpt_fire = (rpt_q == RPT_W'(REPEAT_DELAY - 1));
`endif

  // Saturating candidates, one guard bit so nothing wraps.
  always_comb begin
    sum_x  = {1'b0, duty_q} + STEP_X;
    diff_x = {1'b0, duty_q} - STEP_X;
    if (sum_x > MAX_X) begin
      up_val = MAX_X[DUTY_W-1:0];
    end else begin
      up_val = sum_x[DUTY_W-1:0];
    end
    if (diff_x[DUTY_W]) begin
      dn_val = '0;
    end else begin
      dn_val = diff_x[DUTY_W-1:0];
    end
  end

  // Arbitration FSM: one step per accepted press, none when both held.
  always_comb begin
    st_d  = st_q;
    do_up = 1'b0;
    do_dn = 1'b0;
`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
    rpt_d = '0;
`endif
    unique case (st_q)
      ST_IDLE: begin
        if (up_rise && dn_rise) begin
          st_d = ST_BOTH;
        end else if (up_rise) begin
          if (dn_lvl) begin
            st_d = ST_BOTH;
          end else begin
            st_d  = ST_UP;
            do_up = 1'b1;
          end
        end else if (dn_rise) begin
          if (up_lvl) begin
            st_d = ST_BOTH;
          end else begin
            st_d  = ST_DN;
            do_dn = 1'b1;
          end
        end
      end
      ST_UP: begin
        if (dn_rise) begin
          st_d = ST_BOTH;
        end else if (!up_lvl) begin
          st_d = ST_IDLE;
        end else begin
`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
          if (rpt_fire) begin
            do_up = 1'b1;
            rpt_d = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
`endif
        end
      end
      ST_DN: begin
        if (up_rise) begin
          st_d = ST_BOTH;
        end else if (!dn_lvl) begin
          st_d = ST_IDLE;
        end else begin
`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
          if (rpt_fire) begin
            do_dn = 1'b1;
            rpt_d = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
`endif
        end
      end
      ST_BOTH: begin
        if (!up_lvl && !dn_lvl) begin
          st_d = ST_IDLE;
        end
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // Duty update and change detect; the strobe trails the change by a cycle.
  always_comb begin
    duty_d = duty_q;
    if (do_up) begin
      duty_d = up_val;
    end else if (do_dn) begin
      duty_d = dn_val;
    end
    prev_d = duty_q;
    upd_d  = (duty_q != prev_q);
  end

  // State, duty and strobe registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q   <= ST_IDLE;
      duty_q <= DUTY_W'(RESET_DUTY);
      prev_q <= DUTY_W'(RESET_DUTY);
      upd_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      duty_q <= duty_d;
      prev_q <= prev_d;
      upd_q  <= upd_d;
    end
  end

`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
  // Hold-time counter for auto-repeat, cleared outside UP/DN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`endif

  assign o_duty     = duty_q;
  assign o_duty_upd = upd_q;
  assign o_at_max   = (duty_q == DUTY_W'(DUTY_MAX));
  assign o_at_min   = (duty_q == '0);

endmodule

// File: doc/pwm_duty_ctrl.md
Name: pwm_duty_ctrl

Overview:
Front-end controller for the PWM generator. Takes the two raw push-button inputs (increase/decrease duty) and conditions them: synchronise, debounce, arbitrate. It owns the duty-cycle register, applies saturating steps, and drives the duty value and an update strobe into the PWM counter stage.

Parameters:
DUTY_W, 4, width of duty register and o_duty.
DUTY_STEP, 1, increment/decrement per accepted press; must be ≥1 and < 2^DUTY_W.
RESET_DUTY, 8, o_duty value after reset; must be ≤ 2^DUTY_W-1.
DEB_CYCLES, 4, consecutive stable synchronised samples required to accept a level change; ≥2.
REPEAT_DELAY, 16, hold cycles after first step before auto-repeat starts (AUTO_REPEAT_EN only).
REPEAT_PERIOD, 4, cycles between auto-repeat steps (AUTO_REPEAT_EN only).

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_increase_duty  input  1  raw increase button, asynchronous to i_clk
i_decrease_duty  input  1  raw decrease button, asynchronous to i_clk
o_duty  output  DUTY_W  current duty value to PWM comparator
o_duty_upd  output  1  one-cycle pulse in the cycle after o_duty changes
o_at_max  output  1  o_duty == 2^DUTY_W-1
o_at_min  output  1  o_duty == 0

Behaviour:
- Reset: one clock, asynchronous active-low reset, clock i_clk, reset i_rst_n. Reset forces o_duty=RESET_DUTY, o_duty_upd=0, synchronisers/debounce/repeat counters=0, FSM=IDLE. o_at_max/o_at_min are combinational from o_duty.
- Reset mid-operation: held button is not stepped on release of reset until it debounces high again from 0.
- Sync: each button passes through 2 flops.
- Debounce: a per-button counter counts samples in which the sync output differs from the debounced level. It clears on any sample equal to the level. When it reaches DEB_CYCLES, the level flips and the counter clears. Glitches shorter than DEB_CYCLES samples are ignored.
- Latency: a clean press stable from edge 0 produces the o_duty change at edge 2+DEB_CYCLES+1 (7 at defaults). o_duty_upd is high for the following cycle.
- FSM states: IDLE, UP, DN, BOTH (debounced levels up_d, dn_d).
  - IDLE: on up_d rise with dn_d=0, step up and go to UP. On dn_d rise with up_d=0, step down and go to DN. If both rise in the same cycle, go to BOTH with no step.
  - UP/DN: if the own level falls, go to IDLE. If the other level rises, go to BOTH with no step.
  - BOTH: no steps. Go to IDLE only when both levels are 0. A single released button never re-arms.
- Arithmetic: step up saturates: o_duty = min(o_duty+DUTY_STEP, 2^DUTY_W-1). Step down saturates: max(o_duty-DUTY_STEP, 0). Compute at DUTY_W+1 bits; no wrap-around.
- o_duty_upd fires only if the value actually changed. A press at saturation gives no pulse.

Optional Feature:
Macro: PWM_DUTY_CTRL_AUTO_REPEAT_EN.
- Defined: in UP/DN a repeat counter runs. First auto-step occurs REPEAT_DELAY cycles after the initial step. Later steps occur every REPEAT_PERIOD cycles while held. The counter clears on leaving the state. Saturation rules apply; the counter keeps running at saturation but produces no upd pulse.
- Undefined: exactly one step per debounced press; repeat counter and parameters unused (no logic).

Decomposition:
- Package pwm_ctrl_pkg: FSM state enum (IDLE/UP/DN/BOTH), localparam DUTY_MAX = 2^DUTY_W-1 helper function, and the default parameter constants.
- Sub-module: btn_debounce (2-flop sync + DEB_CYCLES counter, output level and rise pulse), instantiated twice.
- FSM and duty register stay in pwm_duty_ctrl.

Test Plan:
- Reset: assert i_rst_n=0 mid-clock → o_duty=8 immediately, o_duty_upd=0, o_at_max=0, o_at_min=0.
- Clean increase press held 20 cycles from edge 0 → o_duty 8→9 at edge 7, o_duty_upd=1 only at edge 8; no further change (macro off).
- Glitch: i_increase_duty high for 3 cycles, then low → o_duty stays 8, no upd pulse.
- Saturation: 8 separate increase presses → o_duty reaches 15 after 7, o_at_max=1. The 8th press gives no upd. 16 decrease presses → o_duty=0, o_at_min=1.
- Simultaneous: both buttons pressed on the same edge, then increase released, decrease held → o_duty unchanged until both released. A new decrease press then gives 8→7.
- AUTO_REPEAT_EN defined: hold increase from 0 → steps at edges 7, 23, 27, 31…; stops at 15. Release → IDLE.
